// File: rtl/ram_pattern_tester.sv
// Two-pass march-style RAM tester: writes P(a)=a^SEED, reads it back, then repeats with ~P(a).
// Mismatches are counted (saturating) and the first failing address is latched.
`timescale 1ns/1ps
module ram_pattern_tester #(
  parameter int              SIZE      = 8,
  parameter int              DEPTH     = 256,
  parameter logic [SIZE-1:0] SEED      = 8'hA5,
  parameter int              ERR_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic [$clog2(DEPTH)-1:0] ram_address,
  output logic [SIZE-1:0]          ram_write_data,
  output logic                     ram_write_en,
  input  logic [SIZE-1:0]          ram_read_data,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [ERR_WIDTH-1:0]     error_count,
  output logic [$clog2(DEPTH)-1:0] fail_address
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR0,
    RD0,
    WR1,
    RD1,
    DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic                   drain_q, drain_d;
  logic                   tag_valid_q, tag_valid_d;
  logic [AW-1:0]          tag_addr_q, tag_addr_d;
  logic [SIZE-1:0]        wdata_q, wdata_d;
  logic                   we_q, we_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   pass_q, pass_d;
  logic [ERR_WIDTH-1:0]   err_q, err_d;
  logic [AW-1:0]          fail_q, fail_d;
  logic [SIZE-1:0]        expected;
  logic                   mismatch;

  function automatic logic [SIZE-1:0] pattern(input logic [AW-1:0] a, input logic inv);
    logic [SIZE-1:0] p;
    p = SIZE'(a) ^ SEED;
    return inv ? ~p : p;
  endfunction

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    drain_d     = 1'b0;
    tag_valid_d = 1'b0;
    tag_addr_d  = addr_q;
    wdata_d     = '0;
    we_d        = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_d       = err_q;
    fail_d      = fail_q;
    expected    = pattern(tag_addr_q, state_q == RD1);
    mismatch    = tag_valid_q && (ram_read_data != expected);

    // A zero error count means no mismatch has been seen yet, since it saturates instead of wrapping.
    if (mismatch) begin
      if (err_q != '1) err_d = err_q + ERR_WIDTH'(1);
      if (err_q == '0) fail_d = tag_addr_q;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WR0;
          addr_d  = '0;
          we_d    = 1'b1;
          wdata_d = pattern('0, 1'b0);
          busy_d  = 1'b1;
          err_d   = '0;
          fail_d  = '0;
          pass_d  = 1'b0;
        end
      end
      WR0, WR1: begin
        if (addr_q == LAST_ADDR) begin
          state_d = (state_q == WR0) ? RD0 : RD1;
          addr_d  = '0;
        end else begin
          addr_d  = addr_q + AW'(1);
          we_d    = 1'b1;
          wdata_d = pattern(addr_d, state_q == WR1);
        end
      end
      RD0, RD1: begin
        tag_valid_d = !drain_q;
        if (drain_q) begin
          addr_d = '0;
          if (state_q == RD0) begin
            state_d = WR1;
            we_d    = 1'b1;
            wdata_d = pattern('0, 1'b1);
          end else begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end
        end else if (addr_q == LAST_ADDR) begin
          drain_d = 1'b1;
        end else begin
          addr_d = addr_q + AW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      drain_q     <= 1'b0;
      tag_valid_q <= 1'b0;
      tag_addr_q  <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      fail_q      <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      drain_q     <= drain_d;
      tag_valid_q <= tag_valid_d;
      tag_addr_q  <= tag_addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      fail_q      <= fail_d;
    end
  end

  assign ram_address    = addr_q;
  assign ram_write_data = wdata_q;
  assign ram_write_en   = we_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign error_count    = err_q;
  assign fail_address   = fail_q;

endmodule

// File: tb/tb_ram_pattern_tester.sv
// Self-checking bench: a synchronous RAM with injectable read faults, and a
// per-cycle schedule plus an error-count model derived from the pattern rules.
`timescale 1ns/1ps
module tb_ram_pattern_tester;

  localparam int SIZE   = 8;
  localparam int DEPTH  = 8;
  localparam int AW     = $clog2(DEPTH);
  localparam logic [7:0] SEED = 8'hA5;
  localparam int EW     = 2;
  localparam int ERRMAX = (1 << EW) - 1;
  localparam int NCYC   = 4 * DEPTH + 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [AW-1:0]   ramAddress;
  logic [SIZE-1:0] ramWriteData;
  logic            ramWriteEn;
  logic [SIZE-1:0] ramReadData = '0;
  logic            busy;
  logic            done;
  logic            pass;
  logic [EW-1:0]   errorCount;
  logic [AW-1:0]   failAddress;

  int checkCount = 0;
  int failCount  = 0;

  logic [SIZE-1:0] mem [DEPTH];
  int              faultMode = 0;
  int              faultAddr = 0;
  int              faultBit  = 0;
  bit              faultVal  = 1'b0;
  logic [SIZE-1:0] maskArr [DEPTH];

  ram_pattern_tester #(
    .SIZE(SIZE), .DEPTH(DEPTH), .SEED(SEED), .ERR_WIDTH(EW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .ram_address(ramAddress),
    .ram_write_data(ramWriteData),
    .ram_write_en(ramWriteEn),
    .ram_read_data(ramReadData),
    .busy(busy),
    .done(done),
    .pass(pass),
    .error_count(errorCount),
    .fail_address(failAddress)
  );

  always #5 clk = ~clk;

  // Faults are applied on the read path only, so stored contents stay faithful.
  function automatic logic [SIZE-1:0] faultRead(input int a, input logic [SIZE-1:0] d);
    logic [SIZE-1:0] r;
    r = d;
    case (faultMode)
      1: if (a == faultAddr) r[faultBit] = faultVal;
      2: r = '0;
      3: r = d ^ maskArr[a];
      default: r = d;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    if (ramWriteEn) mem[ramAddress] <= ramWriteData;
    ramReadData <= faultRead(int'(ramAddress), mem[ramAddress]);
  end

  function automatic logic [SIZE-1:0] patt(input int a, input bit inv);
    logic [SIZE-1:0] v;
    v = SIZE'(a) ^ SEED;
    return inv ? ~v : v;
  endfunction

  task automatic checkOutput(input string tag, input int got, input int exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected result of a whole run: walk both passes and count read-back differences.
  task automatic computeExpected(output int expErr, output int expFail);
    expErr  = 0;
    expFail = 0;
    for (int p = 0; p < 2; p++) begin
      for (int a = 0; a < DEPTH; a++) begin
        logic [SIZE-1:0] w;
        w = patt(a, p[0]);
        if (faultRead(a, w) != w) begin
          if (expErr == 0) expFail = a;
          if (expErr < ERRMAX) expErr++;
        end
      end
    end
  endtask

  task automatic applyStimulus(input bit holdStart, input bit noisyStart);
    int expErr, expFail, lastK;
    computeExpected(expErr, expFail);
    lastK = holdStart ? NCYC + 2 : NCYC + 1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= lastK; k++) begin
      int  j, eAddr, eData;
      bit  eWe, eBusy, checkData;
      @(negedge clk);
      if (holdStart) start = 1'b1;
      else if (k >= NCYC + 1) start = 1'b0;
      else if (noisyStart) start = 1'($urandom % 2);
      else start = 1'b0;

      eAddr = 0; eData = 0; eWe = 0; eBusy = 1; checkData = 0;
      if (k < DEPTH) begin
        eAddr = k; eWe = 1; eData = int'(patt(k, 1'b0)); checkData = 1;
      end else if (k < 2 * DEPTH + 1) begin
        j = k - DEPTH; eAddr = (j < DEPTH) ? j : DEPTH - 1;
      end else if (k < 3 * DEPTH + 1) begin
        j = k - 2 * DEPTH - 1; eAddr = j; eWe = 1; eData = int'(patt(j, 1'b1)); checkData = 1;
      end else if (k < NCYC) begin
        j = k - 3 * DEPTH - 1; eAddr = (j < DEPTH) ? j : DEPTH - 1;
      end else if (k <= NCYC + 1) begin
        eBusy = 0; checkData = 1;
      end else begin
        eWe = 1; eData = int'(patt(0, 1'b0)); checkData = 1;
      end

      checkOutput("busy", int'(busy), int'(eBusy));
      checkOutput("ram_address", int'(ramAddress), eAddr);
      checkOutput("ram_write_en", int'(ramWriteEn), int'(eWe));
      if (checkData) checkOutput("ram_write_data", int'(ramWriteData), eData);
      checkOutput("done", int'(done), (k == NCYC) ? 1 : 0);
      if (k == 0 || k == NCYC + 2) begin
        checkOutput("start_clears_err", int'(errorCount), 0);
        checkOutput("start_clears_pass", int'(pass), 0);
      end
      if (k == NCYC || k == NCYC + 1) begin
        checkOutput("error_count", int'(errorCount), expErr);
        checkOutput("pass", int'(pass), (expErr == 0) ? 1 : 0);
        if (expErr != 0) checkOutput("fail_address", int'(failAddress), expFail);
      end
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_done"}, int'(done), 0);
    checkOutput({tag, "_pass"}, int'(pass), 0);
    checkOutput({tag, "_err"}, int'(errorCount), 0);
    checkOutput({tag, "_fail"}, int'(failAddress), 0);
    checkOutput({tag, "_addr"}, int'(ramAddress), 0);
    checkOutput({tag, "_we"}, int'(ramWriteEn), 0);
    checkOutput({tag, "_wdata"}, int'(ramWriteData), 0);
  endtask

  task automatic resetDuringRun(input int cyclesIn);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (cyclesIn) @(negedge clk);
    #2 rst = 1'b1;
    #1 checkAllZero("async_rst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_no_done", int'(done), 0);
    end
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    for (int i = 0; i < DEPTH; i++) maskArr[i] = '0;
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;

    faultMode = 0;
    applyStimulus(1'b0, 1'b0);

    faultMode = 1; faultAddr = 3; faultBit = 0; faultVal = 1'b1;
    applyStimulus(1'b0, 1'b0);

    faultMode = 2;
    applyStimulus(1'b0, 1'b0);

    faultMode = 0;
    applyStimulus(1'b1, 1'b0);
    start = 1'b0;
    rst = 1'b1;
    #1 checkAllZero("hold_abort");
    @(negedge clk);
    rst = 1'b0;

    resetDuringRun(DEPTH + 3);
    applyStimulus(1'b0, 1'b0);

    for (int r = 0; r < 20; r++) begin
      faultMode = $urandom_range(0, 3);
      faultAddr = $urandom_range(0, DEPTH - 1);
      faultBit  = $urandom_range(0, SIZE - 1);
      faultVal  = 1'($urandom % 2);
      for (int i = 0; i < DEPTH; i++)
        maskArr[i] = ($urandom % 4 == 0) ? SIZE'($urandom_range(1, 255)) : '0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      applyStimulus(1'b0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
